mem_dump_reader: RTL and testbench

- Sequential readback engine that walks a contiguous range of data memory and streams each word out over a valid/ready interface.
- Address and data are streamed together.
- It is the read-side counterpart to the bench's backdoor memory initialisation, so post-run memory state can be checked through a real port instead of hierarchical peeks.
- It sits beside the cpu and drives the data memory's synchronous read port while the cpu is held idle.

---
 rtl/mem_dump_reader.sv | 162 ++++++++++++++++
 tb/tb_mem_dump_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// Sequential memory readback engine: walks [base_addr, base_addr+word_count) through a
// synchronous read port and streams {address, data} pairs out over valid/ready.
module mem_dump_reader #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {StIdle, StRd, StCap, StSend, StFin} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic [ADDR_W-1:0]   addr_inc;

    assign addr_inc = addr_q + ADDR_W'(1);

    // All outputs are registered, so each transition also loads the values the
    // next state presents (read strobe for RD, done for FIN).
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        checksum_d  = checksum_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d     = base_addr;
                    rem_d      = word_count;
                    checksum_d = '0;
                    busy_d     = 1'b1;
                    if (word_count == '0) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = StRd;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = base_addr;
                    end
                end
            end
            StRd: begin
                state_d = StCap;
            end
            StCap: begin
                out_data_d  = mem_rdata;
                out_addr_d  = addr_q;
                out_valid_d = 1'b1;
                state_d     = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    checksum_d  = checksum_q + out_data_q;
                    out_valid_d = 1'b0;
                    addr_d      = addr_inc;
                    rem_d       = rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = StRd;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = addr_inc;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything, including a transfer in the same cycle.
        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            addr_d      = addr_q;
            rem_d       = rem_q;
            mem_rd_en_d = 1'b0;
            mem_addr_d  = mem_addr_q;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            out_addr_d  = out_addr_q;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            checksum_d  = checksum_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rem_q       <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: directed and randomized dumps against a queue-based
// model of the expected read/transfer sequence and checksum.
module tb_mem_dump_reader;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, abort, out_ready;
    logic [AW-1:0] base_addr, word_count;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          busy, done;
    logic [DW-1:0] checksum;

    mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the ordered list of reads and words a dump must produce.
    logic [AW-1:0] rd_exp[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            n_xfer, n_done, n_rd, cyc, ready_mode;
    bit            mon_en = 1'b0;

    task automatic setup_model(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
        logic [AW-1:0] a;
        rd_exp.delete();
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + AW'(i);
            rd_exp.push_back(a);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
        end
        n_xfer = 0;
        n_done = 0;
        n_rd   = 0;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd_en) begin
                n_rd++;
                if (rd_exp.size() == 0) check("rd_unexpected", 32'(mem_rd_en), 32'd0);
                else check("rd_addr", 32'(mem_addr), 32'(rd_exp.pop_front()));
            end
            if (done) n_done++;
            if (out_valid) begin
                if (exp_addr.size() == 0) begin
                    check("word_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    check("out_addr", 32'(out_addr), 32'(exp_addr[0]));
                    check("out_data", out_data, exp_data[0]);
                    if (out_ready && !abort) begin
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                        n_xfer++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 2);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic run_dump(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                            input int mode, input int abort_n, input bit abort_in_send);
        bit            aborted;
        int            k;
        logic [DW-1:0] exp_sum;
        setup_model(base, cnt);
        ready_mode = mode;
        aborted    = 1'b0;
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        tick();
        start = 1'b0;
        if (cnt == '0) begin
            @(negedge clk);
            check("zero_done_pulse", 32'(done), 32'd1);
        end else begin
            @(negedge clk);
            check("lat_rd_en", 32'(mem_rd_en), 32'd1);
            check("lat_valid_early", 32'(out_valid), 32'd0);
            start      = 1'b1;  // must be ignored while busy
            base_addr  = AW'($urandom);
            word_count = AW'($urandom);
            tick();
            start = 1'b0;
            tick();
            @(negedge clk);
            check("lat_valid", 32'(out_valid), 32'd1);
        end
        for (int i = 0; i < 400; i++) begin
            if (n_done > 0 || aborted) break;
            if (abort_n >= 0 && n_xfer == abort_n && (!abort_in_send || out_valid)) begin
                abort = 1'b1;
                if (abort_in_send) out_ready = 1'b1;
                tick();
                abort   = 1'b0;
                aborted = 1'b1;
            end else begin
                tick();
            end
        end
        if (!(n_done > 0 || aborted)) check("dump_timeout", 32'(n_done), 32'd1);
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        tick();
        tick();
        @(negedge clk);
        k = aborted ? abort_n : int'(cnt);
        exp_sum = '0;
        for (int i = 0; i < k; i++) exp_sum += mem[base + AW'(i)];
        check("xfer_count", 32'(n_xfer), 32'(k));
        check("done_count", 32'(n_done), aborted ? 32'd0 : 32'd1);
        check("checksum", checksum, exp_sum);
        check("busy_after", 32'(busy), 32'd0);
        if (!aborted) check("rd_count", 32'(n_rd), 32'(cnt));
        mon_en = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] rb, rc;
        reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_addr = '0; word_count = '0;
        cyc = 0; ready_mode = 0;
        #12;
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_checksum", checksum, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        mem[10] = 30; mem[11] = 8; mem[12] = 11; mem[13] = 18; mem[14] = 60; mem[15] = 40;

        run_dump(16'd10, 16'd6, 0, -1, 1'b0);
        check("basic_sum_167", checksum, 32'd167);

        run_dump(16'd10, 16'd6, 1, -1, 1'b0);
        check("bp_sum_167", checksum, 32'd167);

        run_dump(16'd10, 16'd0, 0, -1, 1'b0);
        check("zero_sum", checksum, 32'd0);

        for (int i = 0; i < 4; i++) mem[16'hFFFE + 16'(i)] = $urandom;
        run_dump(16'hFFFE, 16'd4, 2, -1, 1'b0);

        run_dump(16'd10, 16'd6, 0, 2, 1'b0);
        check("abort_sum_38", checksum, 32'd38);

        // Abort coinciding with a transfer: that word must not be counted.
        run_dump(16'd10, 16'd6, 1, 3, 1'b1);

        for (int t = 0; t < 4; t++) begin
            rb = AW'($urandom);
            rc = AW'($urandom_range(1, 8));
            for (int i = 0; i < int'(rc); i++) mem[rb + AW'(i)] = $urandom;
            run_dump(rb, rc, 2, -1, 1'b0);
        end

        // Asynchronous reset while stalled in SEND on the second word.
        setup_model(16'd10, 16'd6);
        ready_mode = 0;
        base_addr  = 16'd10;
        word_count = 16'd6;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && n_xfer < 1; i++) tick();
        ready_mode = 3;
        out_ready  = 1'b0;
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_sum", checksum, 32'd30);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_checksum", checksum, 32'd0);
        check("arst_out_data", out_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_dump(16'd10, 16'd6, 2, -1, 1'b0);
        check("post_rst_sum", checksum, 32'd167);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
